// File: rtl/db_multi.sv
// db_multi: N-channel button debouncer.
// Each channel synchronises its raw button, accepts a new level only after
// STABLE_CNT consecutive mismatching synced cycles, and produces a registered
// level, one-cycle rise/fall pulses and an optional press-to-toggle latch.
// Channels share no state; one instance replaces several single debouncers.
`timescale 1ns/1ps

module db_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int STABLE_CNT  = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] toggle_en,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] toggle_out
);

  // The debounced level is the FSM state itself.
  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } state_t;

  // Terminal count: the cycle the counter holds this value while still
  // mismatching is the cycle the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   toggle_q;
    logic                   toggle_d;

    // Synchroniser chain; only its last stage is seen by the debounce logic.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State register: level, stability counter, pulses and toggle latch.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= STABLE_LO;
        cnt_q    <= '0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        toggle_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
        toggle_q <= toggle_d;
      end
    end

    // Next state: count mismatching cycles, flip level at terminal count,
    // and clear the count on any cycle that agrees with the current level.
    always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (s != logic'(state_q)) begin
        if (cnt_q == CNT_MAX) begin
          state_d = state_t'(s);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Outputs: pulses mark the accepted transition, the latch flips on an
    // accepted rise only while toggle mode is enabled.
    always_comb begin
      rise_d   = (state_q == STABLE_LO) && (state_d == STABLE_HI);
      fall_d   = (state_q == STABLE_HI) && (state_d == STABLE_LO);
      toggle_d = toggle_q;
      if (rise_d && toggle_en[i]) begin
        toggle_d = ~toggle_q;
      end
    end

    assign db_out[i]     = logic'(state_q);
    assign rise_pulse[i] = rise_q;
    assign fall_pulse[i] = fall_q;
    assign toggle_out[i] = toggle_q;
  end

endmodule

// File: tb/tb_db_multi.sv
// tb_db_multi: directed self-checking bench for db_multi with
// N_CH=4, STABLE_CNT=4, SYNC_STAGES=2, 4 ns clock. A clean edge therefore
// shows up on db_out 6 rising edges after the first edge that samples it.
`timescale 1ns/1ps

module tb_db_multi;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] toggle_en;
  logic [3:0] db_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic [3:0] toggle_out;

  logic [3:0] btn_v;
  logic [3:0] ten_v;

  int assert_count;
  int fail_count;

  db_multi #(
    .N_CH       (4),
    .CNT_W      (16),
    .STABLE_CNT (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .toggle_en (toggle_en),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  // 4 ns clock, first rising edge at 2 ns.
  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic applyStimulus(input logic [3:0] b, input logic [3:0] t);
    btn_in    = b;
    toggle_en = t;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed,
                             input logic [3:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, leaving time 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Run n cycles while counting pulses on one channel.
  task automatic runCycles(input int n, input int ch, inout int rises, inout int falls);
    for (int k = 0; k < n; k++) begin
      tick(1);
      rises += int'(rise_pulse[ch]);
      falls += int'(fall_pulse[ch]);
    end
  endtask

  // One clean press (10 cycles high) and release (10 cycles low).
  task automatic pressChannel(input int ch, output int rises, output int falls);
    rises = 0;
    falls = 0;
    btn_v[ch] = 1'b1;
    applyStimulus(btn_v, ten_v);
    runCycles(10, ch, rises, falls);
    btn_v[ch] = 1'b0;
    applyStimulus(btn_v, ten_v);
    runCycles(10, ch, rises, falls);
  endtask

  logic [31:0] bounce;
  int          rises;
  int          falls;
  int          early;

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst          = 1'b0;
    btn_v        = 4'h0;
    ten_v        = 4'h0;
    applyStimulus(btn_v, ten_v);

    // Reset asserted between clock edges must clear outputs immediately.
    #1;
    rst   = 1'b1;
    btn_v = 4'hF;
    applyStimulus(btn_v, ten_v);
    #0.5;
    checkOutput("reset_db_out", db_out, 4'h0);
    checkOutput("reset_rise", rise_pulse, 4'h0);
    checkOutput("reset_fall", fall_pulse, 4'h0);
    checkOutput("reset_toggle", toggle_out, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(5);
    checkOutput("release_db_edge5", db_out, 4'h0);
    tick(1);
    checkOutput("release_db_edge6", db_out, 4'hF);
    checkOutput("release_rise_edge6", rise_pulse, 4'hF);
    tick(1);
    checkOutput("release_rise_edge7", rise_pulse, 4'h0);
    checkOutput("release_db_edge7", db_out, 4'hF);

    // Release everything; all channels fall together.
    btn_v = 4'h0;
    applyStimulus(btn_v, ten_v);
    tick(5);
    checkOutput("all_low_db_edge5", db_out, 4'hF);
    tick(1);
    checkOutput("all_low_db_edge6", db_out, 4'h0);
    checkOutput("all_low_fall_edge6", fall_pulse, 4'hF);
    tick(1);
    checkOutput("all_low_fall_edge7", fall_pulse, 4'h0);

    // Bounce pattern on ch0, one bit per cycle, LSB first. The 0101 glitches
    // never reach the threshold; the long high run is accepted (bit 12), the
    // 0000 run is exactly STABLE_CNT long and is accepted as a fall, and the
    // closing 1111 run is accepted as a second rise.
    $display("[TB] bounce pattern on ch0");
    bounce = 32'hF0FF_FEAA;
    rises  = 0;
    falls  = 0;
    early  = 0;
    for (int k = 0; k < 40; k++) begin
      btn_v[0] = (k < 32) ? bounce[k] : 1'b1;
      applyStimulus(btn_v, ten_v);
      tick(1);
      if (k < 14) early += int'(rise_pulse[0] | fall_pulse[0]);
      rises += int'(rise_pulse[0]);
      falls += int'(fall_pulse[0]);
      if (k == 14) checkOutput("bounce_first_accept", {3'b0, db_out[0]}, 4'h1);
    end
    checkOutput("bounce_glitch_pulses", 4'(early), 4'h0);
    checkOutput("bounce_rise_count", 4'(rises), 4'h2);
    checkOutput("bounce_fall_count", 4'(falls), 4'h1);
    checkOutput("bounce_final_db", {3'b0, db_out[0]}, 4'h1);
    btn_v[0] = 1'b0;
    applyStimulus(btn_v, ten_v);
    tick(8);
    checkOutput("bounce_released_db", db_out, 4'h0);

    // Clean press and release on ch1.
    $display("[TB] clean press on ch1");
    btn_v[1] = 1'b1;
    applyStimulus(btn_v, ten_v);
    tick(5);
    checkOutput("press_rise_edge5", rise_pulse, 4'h0);
    tick(1);
    checkOutput("press_rise_edge6", rise_pulse, 4'h2);
    checkOutput("press_db_edge6", db_out, 4'h2);
    tick(1);
    checkOutput("press_rise_edge7", rise_pulse, 4'h0);
    tick(3);
    btn_v[1] = 1'b0;
    applyStimulus(btn_v, ten_v);
    tick(5);
    checkOutput("release_fall_edge5", fall_pulse, 4'h0);
    checkOutput("release_db_hold", db_out, 4'h2);
    tick(1);
    checkOutput("release_fall_edge6", fall_pulse, 4'h2);
    checkOutput("release_db_low", db_out, 4'h0);
    tick(1);
    checkOutput("release_fall_edge7", fall_pulse, 4'h0);

    // ch2 high for 3 synced cycles: one short of acceptance.
    $display("[TB] threshold glitch on ch2");
    rises = 0;
    falls = 0;
    btn_v[2] = 1'b1;
    applyStimulus(btn_v, ten_v);
    runCycles(3, 2, rises, falls);
    btn_v[2] = 1'b0;
    applyStimulus(btn_v, ten_v);
    runCycles(10, 2, rises, falls);
    checkOutput("glitch3_pulses", 4'(rises + falls), 4'h0);
    checkOutput("glitch3_db", db_out, 4'h0);

    // ch2 high for exactly 4 synced cycles: accepted, then falls again.
    btn_v[2] = 1'b1;
    applyStimulus(btn_v, ten_v);
    tick(4);
    btn_v[2] = 1'b0;
    applyStimulus(btn_v, ten_v);
    tick(2);
    checkOutput("glitch4_db", db_out, 4'h4);
    checkOutput("glitch4_rise", rise_pulse, 4'h4);
    tick(4);
    checkOutput("glitch4_fall", fall_pulse, 4'h4);
    checkOutput("glitch4_db_low", db_out, 4'h0);

    // Toggle mode on ch3: three presses flip 1,0,1.
    $display("[TB] toggle on ch3");
    ten_v = 4'h8;
    applyStimulus(btn_v, ten_v);
    tick(1);
    checkOutput("toggle_enable_no_flip", toggle_out, 4'h0);
    pressChannel(3, rises, falls);
    checkOutput("toggle_press1", toggle_out, 4'h8);
    pressChannel(3, rises, falls);
    checkOutput("toggle_press2", toggle_out, 4'h0);
    pressChannel(3, rises, falls);
    checkOutput("toggle_press3", toggle_out, 4'h8);
    ten_v = 4'h0;
    applyStimulus(btn_v, ten_v);
    tick(1);
    checkOutput("toggle_disable_hold", toggle_out, 4'h8);
    pressChannel(3, rises, falls);
    checkOutput("toggle_off_press", toggle_out, 4'h8);
    checkOutput("toggle_off_rise_count", 4'(rises), 4'h1);
    checkOutput("toggle_off_fall_count", 4'(falls), 4'h1);

    // Reset while ch1 holds a partial count of 2.
    $display("[TB] reset mid-count on ch1");
    btn_v[1] = 1'b1;
    applyStimulus(btn_v, ten_v);
    tick(4);
    rst = 1'b1;
    #1;
    checkOutput("midrst_toggle", toggle_out, 4'h0);
    checkOutput("midrst_db", db_out, 4'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    checkOutput("midrst_db_edge5", db_out, 4'h0);
    checkOutput("midrst_rise_edge5", rise_pulse, 4'h0);
    tick(1);
    checkOutput("midrst_db_edge6", db_out, 4'h2);
    checkOutput("midrst_rise_edge6", rise_pulse, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
